counter_mod10: RTL and testbench

- Single-digit BCD down counter, modulus 10, used as one digit of the microwave MS_Timer chain (seconds and minutes digits).
- Loads a preset digit, decrements on enable, and wraps from 0 to 9.
- Provides a terminal-count output that enables the next, more significant digit, and a zero flag used for end-of-time detection.

---
 rtl/counter_mod10.sv | 54 +++++
 tb/tb_counter_mod10.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/counter_mod10.sv
// One BCD down-counting digit for the microwave timer chain.
// Optional: define COUNTER_MOD10_ZERO_HOLD_EN to saturate at 0 instead of wrapping.
module counter_mod10 #(
  parameter int MODULUS = 10,
  parameter int WIDTH   = 4
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             load,
  input  logic             enab,
  input  logic [WIDTH-1:0] numero,
  output logic [WIDTH-1:0] numero_saida,
  output logic             tc_saida,
  output logic             zero_saida
);

  localparam logic [WIDTH-1:0] TOP = WIDTH'(MODULUS - 1);

`ifdef COUNTER_MOD10_ZERO_HOLD_EN
  localparam logic [WIDTH-1:0] WRAP = '0;
`else
  localparam logic [WIDTH-1:0] WRAP = TOP;
`endif

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;
  logic             at_zero;

  assign at_zero = (count_q == '0);

  // next count: load (clamped to the digit range) beats decrement
  always_comb begin
    count_d = count_q;
    if (!load) begin
      count_d = (numero > TOP) ? TOP : numero;
    end else if (enab) begin
      count_d = at_zero ? WRAP : count_q - WIDTH'(1);
    end
  end

  // count register, clear has top priority
  always_ff @(posedge clk) begin
    if (clear) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign numero_saida = count_q;
  assign zero_saida   = at_zero;
  assign tc_saida     = enab & at_zero;

endmodule

// File: tb/tb_counter_mod10.sv
// Scoreboard bench for counter_mod10.
// Follows COUNTER_MOD10_ZERO_HOLD_EN when defined.
module tb_counter_mod10;

  logic       clk = 1'b0;
  logic       clear = 1'b1;
  logic       load = 1'b1;
  logic       enab = 1'b0;
  logic [3:0] numero = 4'd0;
  logic [3:0] numero_saida;
  logic       tc_saida;
  logic       zero_saida;

  int errors = 0;
  int checks = 0;

  logic [3:0] sb[$];
  logic [3:0] cur;
  logic [3:0] pend;
  logic [3:0] exp_q;
  logic       exp_tc;

  counter_mod10 #(.MODULUS(10), .WIDTH(4)) dut (
    .clk(clk),
    .clear(clear),
    .load(load),
    .enab(enab),
    .numero(numero),
    .numero_saida(numero_saida),
    .tc_saida(tc_saida),
    .zero_saida(zero_saida)
  );

  always #5 clk = ~clk;

  function automatic logic [3:0] model(
    input logic c, input logic l, input logic e,
    input logic [3:0] n, input logic [3:0] q
  );
    if (c) return 4'd0;
    if (!l) return (n > 4'd9) ? 4'd9 : n;
    if (e) begin
`ifdef COUNTER_MOD10_ZERO_HOLD_EN
      if (q == 4'd0) return 4'd0;
`else
      if (q == 4'd0) return 4'd9;
`endif
      return q - 4'd1;
    end
    return q;
  endfunction

  task automatic apply(
    input logic c, input logic l, input logic e, input logic [3:0] n
  );
    clear  = c;
    load   = l;
    enab   = e;
    numero = n;
    pend   = model(c, l, e, n, cur);
    sb.push_back(pend);
    exp_tc = e && (cur == 4'd0);
    #1;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
    cur = pend;
    exp_q = sb.pop_front();
  endtask

  task automatic test_reset;
    apply(1'b1, 1'b1, 1'b0, 4'd0);
    tick();
    checks++;
    if (numero_saida !== exp_q) begin
      errors++;
      $display("FAIL reset_count got=%0d exp=%0d", numero_saida, exp_q);
    end
    checks++;
    if (zero_saida !== 1'b1) begin
      errors++;
      $display("FAIL reset_zero got=%b exp=1", zero_saida);
    end
    apply(1'b1, 1'b1, 1'b1, 4'd0);
    checks++;
    if (tc_saida !== exp_tc) begin
      errors++;
      $display("FAIL reset_tc got=%b exp=%b", tc_saida, exp_tc);
    end
    tick();
  endtask

  task automatic test_count_wrap;
    for (int i = 0; i < 11; i++) begin
      apply(1'b0, 1'b1, 1'b1, 4'd0);
      checks++;
      if (tc_saida !== exp_tc) begin
        errors++;
        $display("FAIL wrap_tc[%0d] got=%b exp=%b", i, tc_saida, exp_tc);
      end
      tick();
      checks++;
      if (numero_saida !== exp_q) begin
        errors++;
        $display("FAIL wrap_count[%0d] got=%0d exp=%0d",
                 i, numero_saida, exp_q);
      end
      checks++;
      if (zero_saida !== (exp_q == 4'd0)) begin
        errors++;
        $display("FAIL wrap_zero[%0d] got=%b", i, zero_saida);
      end
    end
  endtask

  task automatic test_load_tc;
    apply(1'b0, 1'b0, 1'b0, 4'd5);
    tick();
    checks++;
    if (numero_saida !== exp_q) begin
      errors++;
      $display("FAIL load5 got=%0d exp=%0d", numero_saida, exp_q);
    end
    for (int i = 0; i < 6; i++) begin
      apply(1'b0, 1'b1, 1'b1, 4'd0);
      checks++;
      if (tc_saida !== exp_tc) begin
        errors++;
        $display("FAIL load_tc[%0d] got=%b exp=%b", i, tc_saida, exp_tc);
      end
      tick();
      checks++;
      if (numero_saida !== exp_q) begin
        errors++;
        $display("FAIL load_count[%0d] got=%0d exp=%0d",
                 i, numero_saida, exp_q);
      end
    end
  endtask

  task automatic test_hold;
    apply(1'b0, 1'b0, 1'b0, 4'd3);
    tick();
    for (int i = 0; i < 3; i++) begin
      apply(1'b0, 1'b1, 1'b0, 4'd8);
      checks++;
      if (tc_saida !== exp_tc) begin
        errors++;
        $display("FAIL hold_tc[%0d] got=%b exp=%b", i, tc_saida, exp_tc);
      end
      tick();
      checks++;
      if (numero_saida !== exp_q) begin
        errors++;
        $display("FAIL hold_count[%0d] got=%0d exp=%0d",
                 i, numero_saida, exp_q);
      end
    end
    apply(1'b0, 1'b0, 1'b0, 4'd0);
    tick();
    apply(1'b0, 1'b1, 1'b0, 4'd0);
    checks++;
    if (zero_saida !== 1'b1 || tc_saida !== exp_tc) begin
      errors++;
      $display("FAIL hold_zero got z=%b tc=%b exp z=1 tc=%b",
               zero_saida, tc_saida, exp_tc);
    end
    tick();
    checks++;
    if (numero_saida !== exp_q) begin
      errors++;
      $display("FAIL hold_zero_count got=%0d exp=%0d", numero_saida, exp_q);
    end
  endtask

  task automatic test_priority;
    apply(1'b0, 1'b0, 1'b0, 4'd4);
    tick();
    apply(1'b1, 1'b0, 1'b1, 4'd7);
    tick();
    checks++;
    if (numero_saida !== exp_q) begin
      errors++;
      $display("FAIL prio_clear got=%0d exp=%0d", numero_saida, exp_q);
    end
    apply(1'b0, 1'b0, 1'b1, 4'd7);
    tick();
    checks++;
    if (numero_saida !== exp_q) begin
      errors++;
      $display("FAIL prio_load got=%0d exp=%0d", numero_saida, exp_q);
    end
    apply(1'b0, 1'b1, 1'b1, 4'd0);
    tick();
    apply(1'b1, 1'b1, 1'b1, 4'd0);
    tick();
    checks++;
    if (numero_saida !== exp_q) begin
      errors++;
      $display("FAIL mid_clear got=%0d exp=%0d", numero_saida, exp_q);
    end
    apply(1'b0, 1'b1, 1'b1, 4'd0);
    tick();
    checks++;
    if (numero_saida !== exp_q) begin
      errors++;
      $display("FAIL after_clear got=%0d exp=%0d", numero_saida, exp_q);
    end
  endtask

  task automatic test_clamp;
    logic [3:0] vals[4];
    vals[0] = 4'd13;
    vals[1] = 4'd15;
    vals[2] = 4'd10;
    vals[3] = 4'd0;
    for (int i = 0; i < 4; i++) begin
      apply(1'b0, 1'b0, 1'b0, vals[i]);
      tick();
      checks++;
      if (numero_saida !== exp_q) begin
        errors++;
        $display("FAIL clamp[%0d] in=%0d got=%0d exp=%0d",
                 i, vals[i], numero_saida, exp_q);
      end
      checks++;
      if (zero_saida !== (exp_q == 4'd0)) begin
        errors++;
        $display("FAIL clamp_zero[%0d] got=%b", i, zero_saida);
      end
    end
  endtask

  task automatic test_zero_edge;
    apply(1'b0, 1'b0, 1'b0, 4'd1);
    tick();
    for (int i = 0; i < 4; i++) begin
      apply(1'b0, 1'b1, 1'b1, 4'd0);
      checks++;
      if (tc_saida !== exp_tc) begin
        errors++;
        $display("FAIL zedge_tc[%0d] got=%b exp=%b", i, tc_saida, exp_tc);
      end
      tick();
      checks++;
      if (numero_saida !== exp_q) begin
        errors++;
        $display("FAIL zedge_count[%0d] got=%0d exp=%0d",
                 i, numero_saida, exp_q);
      end
    end
  endtask

  task automatic test_random;
    logic c, l, e;
    logic [3:0] n;
    for (int i = 0; i < 200; i++) begin
      c = ($urandom_range(0, 15) == 0);
      l = ($urandom_range(0, 5) != 0);
      e = $urandom_range(0, 1) != 0;
      n = 4'($urandom_range(0, 15));
      apply(c, l, e, n);
      checks++;
      if (tc_saida !== exp_tc) begin
        errors++;
        $display("FAIL rnd_tc[%0d] got=%b exp=%b", i, tc_saida, exp_tc);
      end
      tick();
      checks++;
      if (numero_saida !== exp_q) begin
        errors++;
        $display("FAIL rnd_count[%0d] got=%0d exp=%0d",
                 i, numero_saida, exp_q);
      end
    end
  endtask

  initial begin
    cur  = 4'd0;
    pend = 4'd0;
    test_reset();
    test_count_wrap();
    test_load_tc();
    test_hold();
    test_priority();
    test_clamp();
    test_zero_edge();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
